stream_upsizer: RTL and testbench
=================================

STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001 Parameter DWIDTH, default 32, width in bits of one input beat.
REQ-002 Parameter RATIO, default 4, input beats packed per output word; legal range 2..16.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s_valid  input  1  upstream beat valid.
REQ-006 s_data  input  DWIDTH  upstream beat data.
REQ-007 s_last  input  1  final beat of packet (present only with STREAM_UPSIZER_LAST_EN).
REQ-008 s_ready  output  1  upstream beat accepted when s_valid&s_ready.
REQ-009 m_valid  output  1  packed word valid, driven from a register.
REQ-010 m_data  output  DWIDTH*RATIO  packed word, lane k = bits [k*DWIDTH +: DWIDTH].
REQ-011 m_keep  output  RATIO  lane-valid mask (present only with STREAM_UPSIZER_LAST_EN).
REQ-012 m_last  output  1  packed word ends packet (present only with STREAM_UPSIZER_LAST_EN).
REQ-013 m_ready  input  1  downstream accepts word when m_valid&m_ready.

Function
REQ-014 The block SHALL hold a lane counter cnt (0..RATIO-1) and RATIO-1 accumulator lanes; the accepted beat SHALL be written to lane cnt.
REQ-015 s_ready SHALL equal ~m_valid | m_ready, combinationally.
REQ-016 A non-completing accepted beat SHALL store to accumulator lane cnt and increment cnt.
REQ-017 A completing beat (cnt==RATIO-1, or s_last with LAST_EN) SHALL load accumulator lanes 0..cnt-1 plus s_data in lane cnt into the output register, set m_valid, and reset cnt to 0, all in the same edge.
REQ-018 Latency: completing beat accepted at edge t SHALL produce m_valid=1 with the packed word after edge t.
REQ-019 m_valid SHALL clear on an edge where m_valid&m_ready and no completing beat is accepted.
REQ-020 Completing beat accepted while m_valid&m_ready SHALL replace the output word with no bubble; sustained throughput one input beat per cycle.
REQ-021 While m_valid&~m_ready, m_data, m_keep, m_last SHALL stay stable and s_ready SHALL be 0.
REQ-022 Lanes above cnt in a partial word SHALL be driven to zero in m_data.
REQ-023 m_keep SHALL have bits 0..cnt set (cnt as at completion), remaining bits clear; m_last SHALL equal the s_last of the completing beat.
REQ-024 s_last on the first beat (cnt==0) SHALL emit a one-lane word with m_keep=1.
REQ-025 Beats with s_valid=0 SHALL leave cnt and accumulator unchanged; idle gaps within a word are legal.

Reset
REQ-026 rst=1 SHALL immediately force m_valid=0, cnt=0, m_data=0, m_keep=0, m_last=0; accumulator lanes need not reset.
REQ-027 Reset asserted mid-word SHALL discard the partial word; first beat after reset lands in lane 0.

Configuration
REQ-028 Macro STREAM_UPSIZER_LAST_EN defined: s_last, m_keep, m_last ports exist and REQ-017/022/023/024 packet-end rules apply.
REQ-029 STREAM_UPSIZER_LAST_EN undefined: those ports are absent, completion occurs only at cnt==RATIO-1, every word carries exactly RATIO beats.

Verification (DWIDTH=8, RATIO=4, LAST_EN defined unless noted)
REQ-030 Beats 0x11,0x22,0x33,0x44 back-to-back, m_ready=1 -> next cycle m_data=0x44332211, m_keep=0xF, m_last=0, m_valid high one cycle.
REQ-031 Beats 0xA1,0xA2 with s_last on 0xA2 -> m_data=0x0000A2A1, m_keep=0x3, m_last=1; next beat lands in lane 0.
REQ-032 Eight continuous beats 0x01..0x08, m_ready=1 -> words 0x04030201 then 0x08070605 on consecutive-word cadence, s_ready never low.
REQ-033 Word pending, m_ready=0 for 5 cycles -> s_ready=0, m_data stable; m_ready=1 -> word consumed, s_ready=1 same cycle.
REQ-034 Beats 0x55,0x66 then rst pulse, then 0x77,0x88,0x99,0xAA -> all outputs 0 during reset, then m_data=0xAA998877.
REQ-035 LAST_EN undefined: beats 0x01..0x04 -> m_data=0x04030201, no keep/last ports elaborated.

Source files
------------

// File: rtl/stream_upsizer_if.sv
// Stream upsizer port bundle: narrow input beats on the s_* side, packed
// words on the m_* side. The slave modport is the upsizer's own view; the
// master modport is the view of whatever drives and consumes it.
// Optional packet signals (s_last, m_keep, m_last) exist only when
// STREAM_UPSIZER_LAST_EN is defined.
interface stream_upsizer_if #(
    parameter int DWIDTH = 32,
    parameter int RATIO  = 4
);
    logic                      s_valid;
    logic [DWIDTH-1:0]         s_data;
    logic                      s_ready;
    logic                      m_valid;
    logic [DWIDTH*RATIO-1:0]   m_data;
    logic                      m_ready;
`ifdef STREAM_UPSIZER_LAST_EN
    logic                      s_last;
    logic [RATIO-1:0]          m_keep;
    logic                      m_last;
`endif

    modport slave (
        input  s_valid, s_data, m_ready,
`ifdef STREAM_UPSIZER_LAST_EN
        input  s_last,
        output m_keep, m_last,
`endif
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, m_ready,
`ifdef STREAM_UPSIZER_LAST_EN
        output s_last,
        input  m_keep, m_last,
`endif
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO input beats of DWIDTH bits into one output
// word, lane k at bits [k*DWIDTH +: DWIDTH]. Beats accumulate in RATIO-1
// holding lanes; the completing beat goes straight into the output register
// together with the held lanes, so the word appears one edge after it.
// Optional feature macro: STREAM_UPSIZER_LAST_EN adds s_last/m_keep/m_last,
// letting a packet end close a partial word (unused upper lanes zeroed).
module stream_upsizer #(
    parameter int DWIDTH = 32,
    parameter int RATIO  = 4
) (
    input  logic             clk,
    input  logic             rst,
    stream_upsizer_if.slave  up_if
);
    localparam int              CW      = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam int              OW      = DWIDTH * RATIO;
    localparam logic [CW-1:0]   CNT_MAX = CW'(RATIO - 1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic           m_valid_q, m_valid_d;
    logic [OW-1:0]  m_data_q, m_data_d;
    logic [OW-1:0]  word_next;
    logic           s_ready_w;
    logic           accept;
    logic           complete;
    logic           acc_we;
    logic           end_of_word;
`ifdef STREAM_UPSIZER_LAST_EN
    logic [RATIO-1:0] m_keep_q, m_keep_d, keep_next;
    logic             m_last_q, m_last_d;
`endif

    // Input may advance whenever the output register is empty or draining.
    assign s_ready_w = ~m_valid_q | up_if.m_ready;
    assign accept    = up_if.s_valid & s_ready_w;
`ifdef STREAM_UPSIZER_LAST_EN
    assign end_of_word = (cnt_q == CNT_MAX) | up_if.s_last;
`else
    assign end_of_word = (cnt_q == CNT_MAX);
`endif
    assign complete  = accept & end_of_word;
    assign acc_we    = accept & ~end_of_word;

    // Per-lane holding registers and the lane mux that builds the next word:
    // held data below cnt, the live beat at cnt, zeros above it.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
        if (gi < RATIO - 1) begin : g_acc
            logic [DWIDTH-1:0] acc_q;

            // Holding lane: captures a non-completing beat aimed at this lane.
            always_ff @(posedge clk) begin
                if (acc_we && (cnt_q == CW'(gi))) begin
                    acc_q <= up_if.s_data;
                end
            end

            assign word_next[gi*DWIDTH +: DWIDTH] =
                (cnt_q >  CW'(gi)) ? acc_q :
                (cnt_q == CW'(gi)) ? up_if.s_data : '0;
        end else begin : g_top
            // The top lane is only ever filled directly by the completing beat.
            assign word_next[gi*DWIDTH +: DWIDTH] =
                (cnt_q == CNT_MAX) ? up_if.s_data : '0;
        end
`ifdef STREAM_UPSIZER_LAST_EN
        assign keep_next[gi] = (CW'(gi) <= cnt_q);
`endif
    end

    // Next-state: load the output word on completion, otherwise advance the
    // lane counter and drop m_valid once the pending word is taken.
    always_comb begin
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
`ifdef STREAM_UPSIZER_LAST_EN
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;
`endif
        if (complete) begin
            cnt_d     = '0;
            m_valid_d = 1'b1;
            m_data_d  = word_next;
`ifdef STREAM_UPSIZER_LAST_EN
            m_keep_d  = keep_next;
            m_last_d  = up_if.s_last;
`endif
        end else begin
            if (accept) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (m_valid_q && up_if.m_ready) begin
                m_valid_d = 1'b0;
            end
        end
    end

    // Control and output registers; reset drops any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
`ifdef STREAM_UPSIZER_LAST_EN
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
`ifdef STREAM_UPSIZER_LAST_EN
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
`endif
        end
    end

    assign up_if.s_ready = s_ready_w;
    assign up_if.m_valid = m_valid_q;
    assign up_if.m_data  = m_data_q;
`ifdef STREAM_UPSIZER_LAST_EN
    assign up_if.m_keep  = m_keep_q;
    assign up_if.m_last  = m_last_q;
`endif
endmodule

// File: tb/tb_stream_upsizer.sv
// Bench for stream_upsizer (DWIDTH=8, RATIO=4). A beat-list model predicts
// s_ready and the output word every cycle; directed sequences add literal
// checks. Packet-end cases run only when STREAM_UPSIZER_LAST_EN is defined.
module tb_stream_upsizer;
    localparam int DW = 8;
    localparam int RT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   stalls = 0;

    always #5 clk = ~clk;

    stream_upsizer_if #(.DWIDTH(DW), .RATIO(RT)) bus ();

    stream_upsizer #(.DWIDTH(DW), .RATIO(RT)) dut (
        .clk   (clk),
        .rst   (rst),
        .up_if (bus.slave)
    );

    // ---------------- behavioural model ----------------
    logic          exp_valid = 1'b0;
    logic [31:0]   exp_data  = '0;
    logic [3:0]    exp_keep  = '0;
    logic          exp_last  = 1'b0;
    logic [7:0]    part [RT];
    int            pn = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_valid = 1'b0; exp_data = '0; exp_keep = '0; exp_last = 1'b0; pn = 0;
            end else begin
                logic rdy, lst, done;
                rdy = !exp_valid || bus.m_ready;
`ifdef STREAM_UPSIZER_LAST_EN
                lst = bus.s_last;
`else
                lst = 1'b0;
`endif
                done = 1'b0;
                if (bus.s_valid && rdy) begin
                    part[pn] = bus.s_data;
                    pn++;
                    if (pn == RT || lst) begin
                        done = 1'b1;
                        exp_data = '0;
                        for (int i = 0; i < pn; i++) exp_data |= 32'(part[i]) << (DW * i);
                        exp_keep  = 4'((1 << pn) - 1);
                        exp_last  = lst;
                        exp_valid = 1'b1;
                        pn = 0;
                    end
                end
                if (!done && bus.m_ready) exp_valid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("s_ready", 32'(bus.s_ready), 32'(!exp_valid || bus.m_ready));
            check("m_valid", 32'(bus.m_valid), 32'(exp_valid));
            if (exp_valid || rst) begin
                check("m_data", bus.m_data, exp_data);
`ifdef STREAM_UPSIZER_LAST_EN
                check("m_keep", 32'(bus.m_keep), 32'(exp_keep));
                check("m_last", 32'(bus.m_last), 32'(exp_last));
`endif
            end
            if (bus.m_valid && bus.m_ready && !rst)
                $display("[TB] word out data=%08h", bus.m_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] d, input logic l);
        int  n = 0;
        logic ok;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
`ifdef STREAM_UPSIZER_LAST_EN
        bus.s_last  = l;
`else
        if (l) $display("[TB] note: s_last ignored in this build");
`endif
        forever begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 50) begin
                tests++; fails++;
                $display("FAIL send_timeout: got s_ready=0 for %0d cycles required acceptance", n);
                break;
            end
        end
        stalls += n;
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
`ifdef STREAM_UPSIZER_LAST_EN
        bus.s_last  = 1'b0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
`ifdef STREAM_UPSIZER_LAST_EN
        bus.s_last  = 1'b0;
`endif
        // Reset state
        repeat (2) tick();
        check("rst_valid", 32'(bus.m_valid), 32'h0);
        check("rst_data", bus.m_data, 32'h0);
        rst = 1'b0;
        tick();

        // Full word, back to back
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        idle();
        $display("[TB] word 11..44 sent");
        check("full_data", bus.m_data, 32'h44332211);
        check("full_valid", 32'(bus.m_valid), 32'h1);
`ifdef STREAM_UPSIZER_LAST_EN
        check("full_keep", 32'(bus.m_keep), 32'hF);
        check("full_last", 32'(bus.m_last), 32'h0);
`endif
        tick();
        check("full_valid_drop", 32'(bus.m_valid), 32'h0);

`ifdef STREAM_UPSIZER_LAST_EN
        // Short packet, then a single-beat packet landing in lane 0
        send(8'hA1, 1'b0); send(8'hA2, 1'b1);
        idle();
        $display("[TB] packet A1,A2 sent");
        check("short_data", bus.m_data, 32'h0000A2A1);
        check("short_keep", 32'(bus.m_keep), 32'h3);
        check("short_last", 32'(bus.m_last), 32'h1);
        send(8'hB1, 1'b1);
        idle();
        $display("[TB] packet B1 sent");
        check("one_data", bus.m_data, 32'h000000B1);
        check("one_keep", 32'(bus.m_keep), 32'h1);
        tick();
`endif

        // Eight continuous beats, no stalls
        stalls = 0;
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 1'b0);
            if (i == 4) check("stream_w0", bus.m_data, 32'h04030201);
        end
        idle();
        $display("[TB] beats 01..08 sent");
        check("stream_w1", bus.m_data, 32'h08070605);
        check("stream_stalls", 32'(stalls), 32'h0);
        tick();

        // Backpressure: word held while m_ready=0
        bus.m_ready = 1'b0;
        send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hD1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready", 32'(bus.s_ready), 32'h0);
            check("bp_data", bus.m_data, 32'hC4C3C2C1);
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.s_ready), 32'h1);
        tick();
        $display("[TB] backpressured word C1..C4 released");
        check("bp_consumed", 32'(bus.m_valid), 32'h0);
        send(8'hD2, 1'b0); send(8'hD3, 1'b0); send(8'hD4, 1'b0);
        idle();
        check("bp_next", bus.m_data, 32'hD4D3D2D1);
        tick();

        // Reset mid-word discards the partial word
        send(8'h55, 1'b0); send(8'h66, 1'b0);
        idle();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.m_valid), 32'h0);
        check("mid_rst_data", bus.m_data, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        send(8'h77, 1'b0); send(8'h88, 1'b0); send(8'h99, 1'b0); send(8'hAA, 1'b0);
        idle();
        $display("[TB] word 77..AA sent after reset");
        check("post_rst_data", bus.m_data, 32'hAA998877);
        tick();

        // Idle gaps inside a word
        send(8'h01, 1'b0); idle(); tick(); tick();
        send(8'h02, 1'b0); idle(); tick();
        send(8'h03, 1'b0); send(8'h04, 1'b0); idle();
        $display("[TB] gapped word 01..04 sent");
        check("gap_data", bus.m_data, 32'h04030201);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
